// File: rtl/alu_pkg.sv
// Shared ALU opcodes, multiply/divide sequencer state encoding and datapath width.
package alu_pkg;
  localparam int XLEN = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_FIN  = 2'd2
  } mdu_state_e;
endpackage

// File: rtl/alu_mdu_seq_if.sv
// Request/response bundle between the decoder side and the MULTU/DIVU sequencer.
interface alu_mdu_seq_if;
  import alu_pkg::*;

  logic            start;
  logic            op_div;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            div_by_zero;

  modport master (
    output start, op_div, rs_val, rt_val,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op_div, rs_val, rt_val,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/mdu_shift_step.sv
// One shift-add (MULTU) or restoring-subtract (DIVU) iteration around the shared ALU.
module mdu_shift_step
  import alu_pkg::*;
(
  input  logic            op_div,
  input  logic [XLEN-1:0] hw,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opnd,
  input  logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_opcode,
  output logic [XLEN-1:0] hw_n,
  output logic [XLEN-1:0] lo_n
);
  logic [XLEN-1:0] sh;
  logic            top;

  assign sh  = {hw[XLEN-2:0], lo[XLEN-1]};
  assign top = hw[XLEN-1];

  always_comb begin
    alu_a      = hw;
    alu_b      = lo[0] ? opnd : '0;
    alu_opcode = ALU_ADD;
    if (op_div) begin
      alu_a      = sh;
      alu_b      = opnd;
      alu_opcode = ALU_SUB;
    end
  end

  // The bit shifted out of the partial remainder means sh is already >= divisor.
  always_comb begin
    logic q;
    logic carry;
    q     = top | (sh >= opnd);
    carry = (alu_out < hw);
    hw_n  = {carry, alu_out[XLEN-1:1]};
    lo_n  = {alu_out[0], lo[XLEN-1:1]};
    if (op_div) begin
      hw_n = q ? alu_out : sh;
      lo_n = {lo[XLEN-2:0], q};
    end
  end
endmodule

// File: rtl/alu_mdu_seq.sv
// MULTU/DIVU sequencer iterating the shared ALU; writes HI/LO on completion.
// Optional multiply early termination when built with MDU_EARLY_TERM_EN.
module alu_mdu_seq
  import alu_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_mdu_seq_if.slave    mdu,
  output logic            alu_sel,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_opcode,
  input  logic [XLEN-1:0] alu_out
);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  mdu_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic            is_div;
  logic            busy;
  logic            done;
  logic            dbz;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] hw;
  logic [XLEN-1:0] opnd;

  logic [XLEN-1:0] step_a;
  logic [XLEN-1:0] step_b;
  logic [3:0]      step_op;
  logic [XLEN-1:0] hw_n;
  logic [XLEN-1:0] lo_n;
  logic [XLEN-1:0] hw_t;
  logic [XLEN-1:0] lo_t;
  logic            last;
  logic            run;

  mdu_shift_step u_step (
    .op_div     (is_div),
    .hw         (hw),
    .lo         (lo),
    .opnd       (opnd),
    .alu_out    (alu_out),
    .alu_a      (step_a),
    .alu_b      (step_b),
    .alu_opcode (step_op),
    .hw_n       (hw_n),
    .lo_n       (lo_n)
  );

  assign run        = (state == MDU_RUN);
  assign alu_a      = run ? step_a : '0;
  assign alu_b      = run ? step_b : '0;
  assign alu_opcode = run ? step_op : ALU_ADD;

`ifdef MDU_EARLY_TERM_EN
  localparam logic [XLEN-1:0] LOW_MASK = {1'b0, {(XLEN-1){1'b1}}};
  logic [CNT_W-1:0] shamt;
  logic             early;

  // Remaining iterations would only add zero, so shift them out in one go.
  assign shamt        = LAST_CNT - cnt;
  assign early        = !is_div && ((lo_n & (LOW_MASK >> cnt)) == '0);
  assign {hw_t, lo_t} = {hw_n, lo_n} >> shamt;
  assign last         = (cnt == LAST_CNT) || early;
`else
  assign hw_t = hw_n;
  assign lo_t = lo_n;
  assign last = (cnt == LAST_CNT);
`endif

  assign mdu.busy        = busy;
  assign mdu.done        = done;
  assign mdu.hi          = hi;
  assign mdu.lo          = lo;
  assign mdu.div_by_zero = dbz;

  // HI is written on entry to FIN so it is already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= MDU_IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      alu_sel <= 1'b0;
      dbz     <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MDU_IDLE: begin
          if (mdu.start) begin
            is_div <= mdu.op_div;
            cnt    <= '0;
            busy   <= 1'b1;
            dbz    <= 1'b0;
            if (mdu.op_div && (mdu.rt_val == '0)) begin
              state <= MDU_FIN;
              done  <= 1'b1;
              dbz   <= 1'b1;
              hi    <= mdu.rs_val;
              lo    <= '1;
            end else begin
              state   <= MDU_RUN;
              alu_sel <= 1'b1;
              lo      <= mdu.op_div ? mdu.rs_val : mdu.rt_val;
            end
          end
        end
        MDU_RUN: begin
          lo  <= lo_t;
          cnt <= cnt + 1'b1;
          if (last) begin
            state   <= MDU_FIN;
            alu_sel <= 1'b0;
            done    <= 1'b1;
            hi      <= hw_t;
          end
        end
        MDU_FIN: begin
          state <= MDU_IDLE;
          busy  <= 1'b0;
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == MDU_IDLE && mdu.start) begin
      hw   <= '0;
      opnd <= mdu.op_div ? mdu.rt_val : mdu.rs_val;
    end else if (run) begin
      hw <= hw_t;
    end
  end
endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed bench for alu_mdu_seq with a behavioural ADD/SUB ALU in the loop.
module tb_alu_mdu_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_sel;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_opcode;
  int          vec  = 0;
  int          errs = 0;

  alu_mdu_seq_if bus ();

  alu_mdu_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mdu        (bus),
    .alu_sel    (alu_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out)
  );

  assign alu_out = (alu_opcode == 4'b0110) ? (alu_a - alu_b) : (alu_a + alu_b);

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs + 1);
    $fatal(1, "watchdog");
  end

`ifdef MDU_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  task automatic issue(input logic div, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op_div = div;
    bus.rs_val = a;
    bus.rt_val = b;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  // Cycle 1 is the cycle in which start is sampled; returns -1 on timeout.
  task automatic wait_done(input int pulse_at, input logic exp_sub, output int cyc,
                           output int bad_op, output int busy_gap, output int sel_cnt);
    cyc = 2; bad_op = 0; busy_gap = 0; sel_cnt = 0;
    while (cyc < 200 && bus.done !== 1'b1) begin
      if (bus.busy !== 1'b1) busy_gap++;
      if (alu_sel === 1'b1) begin
        sel_cnt++;
        if (alu_opcode !== (exp_sub ? 4'b0110 : 4'b0010)) bad_op++;
      end
      bus.start = (cyc == pulse_at);
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    if (bus.done !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    vec++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    vec++; if (bus.done !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", bus.done); end
    vec++; if (alu_sel !== 1'b0) begin errs++; $display("FAIL reset_alu_sel got %b want 0", alu_sel); end
    vec++; if (bus.div_by_zero !== 1'b0) begin errs++; $display("FAIL reset_dbz got %b want 0", bus.div_by_zero); end
    vec++; if ({bus.hi, bus.lo} !== 64'h0) begin errs++; $display("FAIL reset_hilo got %h want 0", {bus.hi, bus.lo}); end
    vec++; if ({alu_a, alu_b} !== 64'h0) begin errs++; $display("FAIL reset_alu_ab got %h want 0", {alu_a, alu_b}); end
    vec++; if (alu_opcode !== 4'b0010) begin errs++; $display("FAIL reset_opcode got %b want 0010", alu_opcode); end
  endtask

  task automatic test_mul_small();
    int cyc, bad, gap, sel;
    issue(1'b0, 32'd7, 32'd6);
    wait_done(0, 1'b0, cyc, bad, gap, sel);
    vec++; if (cyc !== (EARLY ? 5 : 34)) begin errs++; $display("FAIL mul7x6_latency got %0d want %0d", cyc, EARLY ? 5 : 34); end
    vec++; if (bus.hi !== 32'd0 || bus.lo !== 32'd42) begin errs++; $display("FAIL mul7x6_result got %h_%h want 0_2a", bus.hi, bus.lo); end
    vec++; if (gap !== 0 || bus.busy !== 1'b1) begin errs++; $display("FAIL mul7x6_busy gaps %0d busy_at_done %b want 0/1", gap, bus.busy); end
    vec++; if (bad !== 0) begin errs++; $display("FAIL mul7x6_opcode non-ADD cycles %0d want 0", bad); end
    vec++; if (sel !== (EARLY ? 3 : 32) || alu_sel !== 1'b0) begin errs++; $display("FAIL mul7x6_alu_sel cycles %0d sel_at_done %b want %0d/0", sel, alu_sel, EARLY ? 3 : 32); end
    @(negedge clk);
    vec++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errs++; $display("FAIL mul7x6_after done %b busy %b want 0/0", bus.done, bus.busy); end
  endtask

  task automatic test_mul_wide();
    int cyc, bad, gap, sel;
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0, 1'b0, cyc, bad, gap, sel);
    vec++; if (cyc !== 34) begin errs++; $display("FAIL mulmax_latency got %0d want 34", cyc); end
    vec++; if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin errs++; $display("FAIL mulmax_result got %h_%h want fffffffe_00000001", bus.hi, bus.lo); end
    issue(1'b0, 32'hFFFF_FFFF, 32'd2);
    wait_done(0, 1'b0, cyc, bad, gap, sel);
    vec++; if (bus.hi !== 32'd1 || bus.lo !== 32'hFFFF_FFFE || cyc !== (EARLY ? 4 : 34)) begin errs++; $display("FAIL mulx2_result got %h_%h lat %0d want 00000001_fffffffe", bus.hi, bus.lo, cyc); end
    issue(1'b0, 32'h0001_0000, 32'h0001_0000);
    wait_done(0, 1'b0, cyc, bad, gap, sel);
    vec++; if (bus.hi !== 32'd1 || bus.lo !== 32'd0) begin errs++; $display("FAIL mul2p16_result got %h_%h want 00000001_00000000", bus.hi, bus.lo); end
  endtask

  task automatic test_div();
    int cyc, bad, gap, sel;
    issue(1'b1, 32'd100, 32'd7);
    wait_done(0, 1'b1, cyc, bad, gap, sel);
    vec++; if (cyc !== 34) begin errs++; $display("FAIL div100_7_latency got %0d want 34", cyc); end
    vec++; if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin errs++; $display("FAIL div100_7_result q %0d r %0d want 14/2", bus.lo, bus.hi); end
    vec++; if (bad !== 0 || sel !== 32) begin errs++; $display("FAIL div_opcode non-SUB %0d sel %0d want 0/32", bad, sel); end
    vec++; if (bus.div_by_zero !== 1'b0) begin errs++; $display("FAIL div_dbz got %b want 0", bus.div_by_zero); end
    issue(1'b1, 32'hFFFF_FFFF, 32'd1);
    wait_done(0, 1'b1, cyc, bad, gap, sel);
    vec++; if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'd0) begin errs++; $display("FAIL divmax_1_result q %h r %h want ffffffff/0", bus.lo, bus.hi); end
    issue(1'b1, 32'h8000_0000, 32'd3);
    wait_done(0, 1'b1, cyc, bad, gap, sel);
    vec++; if (bus.lo !== 32'h2AAA_AAAA || bus.hi !== 32'd2) begin errs++; $display("FAIL div2p31_3_result q %h r %h want 2aaaaaaa/2", bus.lo, bus.hi); end
    issue(1'b1, 32'd7, 32'd100);
    wait_done(0, 1'b1, cyc, bad, gap, sel);
    vec++; if (bus.lo !== 32'd0 || bus.hi !== 32'd7) begin errs++; $display("FAIL div7_100_result q %h r %h want 0/7", bus.lo, bus.hi); end
  endtask

  task automatic test_div_zero();
    int cyc, bad, gap, sel;
    issue(1'b1, 32'd5, 32'd0);
    wait_done(0, 1'b1, cyc, bad, gap, sel);
    vec++; if (cyc !== 2) begin errs++; $display("FAIL dbz_latency got %0d want 2", cyc); end
    vec++; if (bus.hi !== 32'd5 || bus.lo !== 32'hFFFF_FFFF) begin errs++; $display("FAIL dbz_result got %h_%h want 00000005_ffffffff", bus.hi, bus.lo); end
    vec++; if (bus.div_by_zero !== 1'b1 || sel !== 0) begin errs++; $display("FAIL dbz_flag got %b sel %0d want 1/0", bus.div_by_zero, sel); end
    repeat (3) @(negedge clk);
    vec++; if (bus.div_by_zero !== 1'b1 || bus.hi !== 32'd5) begin errs++; $display("FAIL dbz_sticky flag %b hi %h want 1/5", bus.div_by_zero, bus.hi); end
    issue(1'b0, 32'd3, 32'd4);
    vec++; if (bus.div_by_zero !== 1'b0) begin errs++; $display("FAIL dbz_clear got %b want 0", bus.div_by_zero); end
    wait_done(0, 1'b0, cyc, bad, gap, sel);
    vec++; if (bus.lo !== 32'd12 || bus.hi !== 32'd0) begin errs++; $display("FAIL dbz_next_mul got %h_%h want 0_c", bus.hi, bus.lo); end
  endtask

  task automatic test_start_while_busy();
    int cyc, bad, gap, sel;
    int extra = 0;
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(10, 1'b0, cyc, bad, gap, sel);
    vec++; if (cyc !== 34) begin errs++; $display("FAIL busy_start_latency got %0d want 34", cyc); end
    vec++; if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h1) begin errs++; $display("FAIL busy_start_result got %h_%h want fffffffe_00000001", bus.hi, bus.lo); end
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
    end
    vec++; if (extra !== 0) begin errs++; $display("FAIL busy_start_queued extra busy/done cycles %0d want 0", extra); end
  endtask

  task automatic test_reset_mid();
    int cyc, bad, gap, sel;
    issue(1'b1, 32'd100, 32'd7);
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || alu_sel !== 1'b0) begin errs++; $display("FAIL midreset_ctrl busy %b done %b sel %b want 0/0/0", bus.busy, bus.done, alu_sel); end
    vec++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin errs++; $display("FAIL midreset_hilo got %h_%h want 0_0", bus.hi, bus.lo); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    vec++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errs++; $display("FAIL midreset_aborted done %b busy %b want 0/0", bus.done, bus.busy); end
    issue(1'b0, 32'd3, 32'd3);
    wait_done(0, 1'b0, cyc, bad, gap, sel);
    vec++; if (bus.lo !== 32'd9 || bus.hi !== 32'd0) begin errs++; $display("FAIL midreset_mul3x3 got %h_%h want 0_9", bus.hi, bus.lo); end
    vec++; if (cyc !== (EARLY ? 4 : 34)) begin errs++; $display("FAIL midreset_mul3x3_latency got %0d want %0d", cyc, EARLY ? 4 : 34); end
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.op_div = 1'b0;
    bus.rs_val = 32'd0;
    bus.rt_val = 32'd0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_mul_small();
    test_mul_wide();
    test_div();
    test_div_zero();
    test_start_while_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
- Multi-cycle sequencer that implements MULTU and DIVU (32x32, unsigned) by iterating the shared 32-bit ALU with its ADD and SUB opcodes.
- Sits beside the single-cycle datapath. While busy it owns the ALU through a top-level mux driven by alu_sel; otherwise the main decoder owns the ALU.
- Results go to HI/LO registers for MFHI/MFLO.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- op_div  in  1  0 = MULTU, 1 = DIVU; captured with start.
- rs_val  in  32  multiplicand / dividend.
- rt_val  in  32  multiplier / divisor.
- alu_sel  out  1  1 = sequencer drives the ALU inputs.
- alu_a  out  32  ALU operand a.
- alu_b  out  32  ALU operand b.
- alu_opcode  out  4  ADD = 4'b0010, SUB = 4'b0110.
- alu_out  in  32  ALU result (combinational, same cycle).
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- hi  out  32  product high word / remainder.
- lo  out  32  product low word / quotient.
- div_by_zero  out  1  sticky flag; cleared on the next accepted start.

Behaviour:
- Reset (async, rst_n = 0):
  - State = IDLE.
  - busy, done, alu_sel, div_by_zero = 0.
  - hi, lo, alu_a, alu_b = 0.
  - alu_opcode = ADD.
- States: IDLE -> RUN -> FIN -> IDLE.
- IDLE:
  - start = 1 captures op_div, rs_val and rt_val, and sets cnt = 0.
  - DIVU with rt_val == 0: go directly to FIN with hi = rs_val, lo = 32'hFFFFFFFF, div_by_zero = 1.
  - Otherwise go to RUN.
  - MULTU: acc = 0, lo = rt_val, mcand = rs_val.
  - DIVU: rem = 0, lo = rs_val, dvsr = rt_val.
- RUN: busy = alu_sel = 1. One iteration per cycle, 32 iterations (cnt 0..31); cnt == 31 moves to FIN.
- MULTU iteration:
  - alu_a = acc; alu_b = lo[0] ? mcand : 0; opcode ADD.
  - carry = (alu_out < acc), unsigned, computed locally.
  - {acc, lo} <= {carry, alu_out, lo[31:1]}.
- DIVU iteration:
  - sh = {rem[30:0], lo[31]}; top = rem[31].
  - alu_a = sh; alu_b = dvsr; opcode SUB.
  - q = top | (sh >= dvsr).
  - rem <= q ? alu_out : sh.
  - lo <= {lo[30:0], q}.
- FIN:
  - hi <= acc (MULTU) or rem (DIVU).
  - done = 1 for exactly one cycle; busy = 1 in this cycle, alu_sel = 0.
  - Next state IDLE.
- Latency: start cycle + 32 RUN + 1 FIN, so done asserts 34 cycles after start is sampled (2 cycles for divide-by-zero).
- hi/lo hold their values until the next FIN. Between start and FIN, lo holds working data and is not architecturally valid.
- start while busy is ignored and not queued.
- rst_n asserted mid-operation aborts immediately to reset values. No done pulse is produced.
- alu_zero is not used.

Optional Feature:
- Macro MDU_EARLY_TERM_EN.
- Defined: in MULTU RUN, if the remaining multiplier bits lo >> 1 are 0 after an iteration, the block shifts out the remaining positions combinationally ({acc, lo} aligned by 31 - cnt) and goes to FIN next cycle. Results are identical to the full run; only latency shrinks, and done may come earlier. DIVU is unaffected.
- Undefined: always 32 iterations.

Decomposition:
- Shared package alu_pkg holds:
  - ALU opcode localparams ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR.
  - State encoding MDU_IDLE = 2'd0, MDU_RUN = 2'd1, MDU_FIN = 2'd2.
  - XLEN.
- The ALU is used as an existing instance and the top-level mux lives in the datapath; no new sub-module is needed.
- Optional sub-module: mdu_shift_step, the combinational per-iteration next-state logic for MUL/DIV, unit-testable against a reference model.

Test Plan:
- MULTU 7 x 6 -> done 34 cycles after start; hi = 0, lo = 42; busy high for cycles 1..34; alu_opcode = ADD throughout RUN.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001.
- DIVU 100 / 7 -> lo = 14, hi = 2. DIVU 0xFFFFFFFF / 1 -> lo = 0xFFFFFFFF, hi = 0. alu_opcode = SUB during RUN.
- DIVU 5 / 0 -> done 2 cycles after start; hi = 5, lo = 0xFFFFFFFF, div_by_zero = 1. A following MULTU clears the flag.
- start pulsed at cycle 10 of a running MULTU -> ignored; result unchanged; exactly one done pulse.
- rst_n low at cycle 15 of a DIVU -> busy, done, hi and lo return to 0 asynchronously. A new start after release completes correctly (MULTU 3 x 3 -> lo = 9). With MDU_EARLY_TERM_EN defined, 3 x 3 completes in 4 cycles.
